// File: rtl/vga_timing_monitor.sv
// VGA raster timing monitor: measures HS/VS timing and lit pixels, and checks them against the
// expected raster. Define VGA_MON_TIMEOUT_EN to add a watchdog against a dead vertical sync.
module vga_timing_monitor #(
    parameter int unsigned PIX_DIV     = 2,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter bit          SYNC_NEG    = 1'b1,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        CLK1_50,
    input  logic        RESET,
    input  logic [3:0]  VGA_R,
    input  logic [3:0]  VGA_G,
    input  logic [3:0]  VGA_B,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        ERR_CLR,
    output logic [15:0] LINE_LEN,
    output logic [15:0] HS_WIDTH,
    output logic [15:0] FRAME_LINES,
    output logic [15:0] VS_WIDTH,
    output logic [19:0] LIT_PIX,
    output logic [15:0] FRAME_CNT,
    output logic        LOCKED,
    output logic [3:0]  ERR
);

    localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);

    typedef enum logic [1:0] {StAcquire, StMeasure, StTrack} state_e;

    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [19:0] sat20(input logic [19:0] v);
        return (v == 20'hFFFFF) ? v : v + 20'd1;
    endfunction

    state_e           r_state;
    state_e           w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [11:0]      r_rgb;
    logic             r_hs_a;
    logic             r_vs_a;
    logic             r_hs_p;
    logic             r_vs_p;
    logic [15:0]      r_pix_cnt;
    logic [15:0]      r_hs_cnt;
    logic [15:0]      r_line_cnt;
    logic [15:0]      r_vsw_cnt;
    logic [19:0]      r_lit_acc;
    logic             r_have_edge;
    logic [15:0]      r_line_len;
    logic [15:0]      r_hs_width;
    logic [15:0]      r_frame_lines;
    logic [15:0]      r_vs_width;
    logic [19:0]      r_lit_pix;
    logic [15:0]      r_frame_cnt;
    logic             r_locked;
    logic [15:0]      r_clean;
    logic             r_dirty;
    logic [3:0]       r_err;

    logic             w_pix_en;
    logic             w_hs_lead;
    logic             w_hs_trail;
    logic             w_vs_lead;
    logic             w_vs_trail;
    logic             w_lit;
    logic [15:0]      w_frame_lines_new;
    logic             w_capture;
    logic             w_cmp;
    logic             w_cap_line;
    logic             w_cap_hsw;
    logic             w_cap_fl;
    logic             w_cap_vsw;
    logic [3:0]       w_mis;
    logic             w_timeout;
    logic [3:0]       w_err_set;

    // Pixel-rate strobe: one CLK1_50 cycle in PIX_DIV.
    always_ff @(posedge CLK1_50) begin
        if (RESET) begin
            r_div <= '0;
        end else if (r_div == DIV_MAX) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign w_pix_en = (r_div == '0);

    // Syncs are held as active-level so the reset value means "inactive".
    always_ff @(posedge CLK1_50) begin
        if (RESET) begin
            r_rgb  <= '0;
            r_hs_a <= 1'b0;
            r_vs_a <= 1'b0;
            r_hs_p <= 1'b0;
            r_vs_p <= 1'b0;
        end else begin
            r_rgb  <= {VGA_R, VGA_G, VGA_B};
            r_hs_a <= VGA_HS ^ SYNC_NEG;
            r_vs_a <= VGA_VS ^ SYNC_NEG;
            if (w_pix_en) begin
                r_hs_p <= r_hs_a;
                r_vs_p <= r_vs_a;
            end
        end
    end

    assign w_hs_lead  = w_pix_en & r_hs_a & ~r_hs_p;
    assign w_hs_trail = w_pix_en & ~r_hs_a & r_hs_p;
    assign w_vs_lead  = w_pix_en & r_vs_a & ~r_vs_p;
    assign w_vs_trail = w_pix_en & ~r_vs_a & r_vs_p;
    assign w_lit      = (|r_rgb) & ~r_hs_a & ~r_vs_a;

    // A line starting together with VS belongs to the frame being closed.
    assign w_frame_lines_new = w_hs_lead ? sat16(r_line_cnt) : r_line_cnt;

    assign w_capture  = (r_state != StAcquire);
    assign w_cmp      = (r_state == StTrack);
    assign w_cap_line = w_hs_lead & r_have_edge & w_capture;
    assign w_cap_hsw  = w_hs_trail & w_capture;
    assign w_cap_fl   = w_vs_lead & w_capture;
    assign w_cap_vsw  = w_vs_trail & w_capture;

    assign w_mis[0] = w_cmp & w_cap_line & (r_pix_cnt != 16'(H_TOTAL));
    assign w_mis[1] = w_cmp & w_cap_hsw & (r_hs_cnt != 16'(H_SYNC));
    assign w_mis[2] = w_cmp & w_cap_fl & (w_frame_lines_new != 16'(V_TOTAL));
    assign w_mis[3] = w_cmp & w_cap_vsw & (r_vsw_cnt != 16'(V_SYNC));

`ifdef VGA_MON_TIMEOUT_EN
    localparam logic [31:0] WDOG_LIMIT = 32'(2 * H_TOTAL * V_TOTAL);

    logic [31:0] r_wdog;

    always_ff @(posedge CLK1_50) begin
        if (RESET || w_vs_lead || w_timeout) begin
            r_wdog <= '0;
        end else if (w_pix_en) begin
            r_wdog <= r_wdog + 32'd1;
        end
    end

    assign w_timeout = w_pix_en & ~w_vs_lead & ((r_wdog + 32'd1) == WDOG_LIMIT);
`else
    assign w_timeout = 1'b0;
`endif

    assign w_err_set = w_mis | {1'b0, w_timeout, 2'b00};

    // Running counters; all saturate rather than wrap.
    always_ff @(posedge CLK1_50) begin
        if (RESET) begin
            r_pix_cnt   <= '0;
            r_hs_cnt    <= '0;
            r_line_cnt  <= '0;
            r_vsw_cnt   <= '0;
            r_lit_acc   <= '0;
            r_have_edge <= 1'b0;
        end else if (w_pix_en) begin
            r_pix_cnt <= w_hs_lead ? 16'd1 : sat16(r_pix_cnt);

            if (w_hs_lead) begin
                r_hs_cnt <= 16'd1;
            end else if (r_hs_a) begin
                r_hs_cnt <= sat16(r_hs_cnt);
            end

            if (w_vs_lead) begin
                r_line_cnt <= '0;
                r_vsw_cnt  <= w_hs_lead ? 16'd1 : 16'd0;
                r_lit_acc  <= '0;
            end else begin
                if (w_hs_lead) begin
                    r_line_cnt <= sat16(r_line_cnt);
                end
                if (w_hs_lead && r_vs_a) begin
                    r_vsw_cnt <= sat16(r_vsw_cnt);
                end
                if (w_lit) begin
                    r_lit_acc <= sat20(r_lit_acc);
                end
            end

            if (w_timeout) begin
                r_have_edge <= 1'b0;
            end else if (w_hs_lead) begin
                r_have_edge <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK1_50) begin
        if (RESET) begin
            r_line_len    <= '0;
            r_hs_width    <= '0;
            r_frame_lines <= '0;
            r_vs_width    <= '0;
            r_lit_pix     <= '0;
            r_frame_cnt   <= '0;
        end else begin
            if (w_cap_line) r_line_len <= r_pix_cnt;
            if (w_cap_hsw)  r_hs_width <= r_hs_cnt;
            if (w_cap_vsw)  r_vs_width <= r_vsw_cnt;
            if (w_cap_fl) begin
                r_frame_lines <= w_frame_lines_new;
                r_lit_pix     <= r_lit_acc;
            end
            if (w_vs_lead) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // Lock tracking: a frame is clean only if nothing mismatched between its VS leading edges.
    always_ff @(posedge CLK1_50) begin
        if (RESET) begin
            r_locked <= 1'b0;
            r_clean  <= '0;
            r_dirty  <= 1'b0;
            r_err    <= '0;
        end else begin
            r_err <= (ERR_CLR ? 4'b0000 : r_err) | w_err_set;

            if (w_vs_lead) begin
                r_dirty <= 1'b0;
            end else if (|w_mis) begin
                r_dirty <= 1'b1;
            end

            if ((|w_mis) || w_timeout) begin
                r_locked <= 1'b0;
                r_clean  <= '0;
            end else if (w_vs_lead && w_cmp) begin
                if (r_dirty) begin
                    r_clean <= '0;
                end else begin
                    r_clean <= sat16(r_clean);
                    if ((32'(r_clean) + 32'd1) >= LOCK_FRAMES) begin
                        r_locked <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK1_50) begin
        if (RESET) begin
            r_state <= StAcquire;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StAcquire: if (w_vs_lead) w_state_nxt = StMeasure;
            StMeasure: if (w_vs_lead) w_state_nxt = StTrack;
            StTrack:   w_state_nxt = StTrack;
            default:   w_state_nxt = StAcquire;
        endcase
        if (w_timeout) begin
            w_state_nxt = StAcquire;
        end
    end

    assign LINE_LEN    = r_line_len;
    assign HS_WIDTH    = r_hs_width;
    assign FRAME_LINES = r_frame_lines;
    assign VS_WIDTH    = r_vs_width;
    assign LIT_PIX     = r_lit_pix;
    assign FRAME_CNT   = r_frame_cnt;
    assign LOCKED      = r_locked;
    assign ERR         = r_err;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a scaled-down raster (20x12 pixels, 4/2 syncs).
// The dead-sync expectations follow VGA_MON_TIMEOUT_EN when it is defined.
module tb_vga_timing_monitor;

    localparam int unsigned PD    = 2;
    localparam int unsigned HT    = 20;
    localparam int unsigned HSW   = 4;
    localparam int unsigned VT    = 12;
    localparam int unsigned VSY   = 2;
    localparam int          BOX_X = 6;
    localparam int          BOX_W = 5;
    localparam int          BOX_Y = 4;
    localparam int          BOX_H = 4;
    localparam logic        SN    = 1'b1;

    logic        clk = 1'b0;
    logic        RESET;
    logic [3:0]  VGA_R;
    logic [3:0]  VGA_G;
    logic [3:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        ERR_CLR;
    logic [15:0] LINE_LEN;
    logic [15:0] HS_WIDTH;
    logic [15:0] FRAME_LINES;
    logic [15:0] VS_WIDTH;
    logic [19:0] LIT_PIX;
    logic [15:0] FRAME_CNT;
    logic        LOCKED;
    logic [3:0]  ERR;

    int   n_cmp = 0;
    int   n_mis = 0;
    bit   watch_on = 1'b0;
    bit   seen = 1'b0;
    logic locked_seen;
    logic [3:0] err_seen;

    vga_timing_monitor #(
        .PIX_DIV    (PD),
        .H_TOTAL    (HT),
        .H_SYNC     (HSW),
        .V_TOTAL    (VT),
        .V_SYNC     (VSY),
        .SYNC_NEG   (SN),
        .LOCK_FRAMES(2)
    ) u_dut (
        .CLK1_50    (clk),
        .RESET      (RESET),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B),
        .VGA_HS     (VGA_HS),
        .VGA_VS     (VGA_VS),
        .ERR_CLR    (ERR_CLR),
        .LINE_LEN   (LINE_LEN),
        .HS_WIDTH   (HS_WIDTH),
        .FRAME_LINES(FRAME_LINES),
        .VS_WIDTH   (VS_WIDTH),
        .LIT_PIX    (LIT_PIX),
        .FRAME_CNT  (FRAME_CNT),
        .LOCKED     (LOCKED),
        .ERR        (ERR)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One pixel, held PD clocks; ERR_CLR (if requested) covers only its first clock.
    task automatic pix(input logic hs, input logic vs, input logic lit, input logic clr);
        VGA_HS  = hs ^ SN;
        VGA_VS  = vs ^ SN;
        VGA_R   = lit ? 4'hF : 4'h0;
        VGA_G   = lit ? 4'hF : 4'h0;
        VGA_B   = lit ? 4'hF : 4'h0;
        ERR_CLR = clr;
        for (int i = 0; i < PD; i++) begin
            @(negedge clk);
            ERR_CLR = 1'b0;
            if (watch_on && !seen && LINE_LEN == 16'(HT + 1)) begin
                seen        = 1'b1;
                locked_seen = LOCKED;
                err_seen    = ERR;
            end
        end
    endtask

    task automatic line(input int len, input int hsw, input logic vs, input logic box,
                        input int clr_at);
        for (int x = 0; x < len; x++) begin
            pix(x < hsw, vs, box && (x >= BOX_X) && (x < BOX_X + BOX_W), x == clr_at);
        end
    endtask

    // bad: line made one pixel long; shrt: line with HS one pixel short plus ERR_CLR collision.
    task automatic frame(input int first, input int last, input int bad, input int shrt);
        int len;
        int hsw;
        int clr_at;
        for (int y = first; y <= last; y++) begin
            len    = (y == bad) ? HT + 1 : HT;
            hsw    = (y == shrt) ? HSW - 1 : HSW;
            clr_at = (y == shrt) ? HSW : -1;
            line(len, hsw, y < VSY, (y >= BOX_Y) && (y < BOX_Y + BOX_H), clr_at);
        end
    endtask

    task automatic full_frame();
        frame(0, VT - 1, -1, -1);
    endtask

    initial begin
        RESET   = 1'b1;
        ERR_CLR = 1'b0;
        VGA_R   = '0;
        VGA_G   = '0;
        VGA_B   = '0;
        VGA_HS  = ~SN;
        VGA_VS  = ~SN;
        repeat (4) @(negedge clk);
        chk("rst_line_len", LINE_LEN, 0);
        chk("rst_frame_cnt", FRAME_CNT, 0);
        chk("rst_lit_pix", LIT_PIX, 0);
        chk("rst_err", ERR, 0);
        chk("rst_locked", LOCKED, 0);
        RESET = 1'b0;

        // Ideal raster: ACQUIRE -> MEASURE -> TRACK, lock after two clean TRACK frames.
        full_frame();
        chk("f1_frame_cnt", FRAME_CNT, 1);
        full_frame();
        full_frame();
        chk("f3_line_len", LINE_LEN, HT);
        chk("f3_hs_width", HS_WIDTH, HSW);
        chk("f3_frame_lines", FRAME_LINES, VT);
        chk("f3_vs_width", VS_WIDTH, VSY);
        chk("f3_lit_pix", LIT_PIX, BOX_W * BOX_H);
        chk("f3_err", ERR, 0);
        chk("f3_frame_cnt", FRAME_CNT, 3);
        chk("f3_locked", LOCKED, 0);
        full_frame();
        chk("f4_locked", LOCKED, 1);
        chk("f4_frame_cnt", FRAME_CNT, 4);

        // One 21-pixel line while locked.
        watch_on = 1'b1;
        frame(0, VT - 1, 3, -1);
        watch_on = 1'b0;
        chk("bad_seen", 32'(seen), 1);
        chk("bad_locked_same_cycle", 32'(locked_seen), 0);
        chk("bad_err_same_cycle", 32'(err_seen), 4'b0001);
        chk("bad_line_len_after", LINE_LEN, HT);
        chk("bad_locked_after", LOCKED, 0);
        full_frame();
        full_frame();
        chk("relock_one_clean", LOCKED, 0);
        full_frame();
        chk("relock_two_clean", LOCKED, 1);
        chk("err0_sticky", ERR, 4'b0001);

        // Short HS captured in the same cycle as ERR_CLR.
        frame(0, VT - 1, -1, 2);
        chk("clr_collision_err", ERR, 4'b0010);
        chk("clr_collision_locked", LOCKED, 0);
        chk("clr_collision_hs_width", HS_WIDTH, HSW);

        // Reset in mid-frame.
        frame(0, 5, -1, -1);
        RESET = 1'b1;
        pix(1'b0, 1'b0, 1'b0, 1'b0);
        pix(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_line_len", LINE_LEN, 0);
        chk("mid_rst_hs_width", HS_WIDTH, 0);
        chk("mid_rst_frame_lines", FRAME_LINES, 0);
        chk("mid_rst_vs_width", VS_WIDTH, 0);
        chk("mid_rst_lit_pix", LIT_PIX, 0);
        chk("mid_rst_frame_cnt", FRAME_CNT, 0);
        chk("mid_rst_locked", LOCKED, 0);
        chk("mid_rst_err", ERR, 0);
        RESET = 1'b0;
        frame(6, VT - 1, -1, -1);
        chk("partial_frame_cnt", FRAME_CNT, 0);
        chk("partial_err", ERR, 0);
        full_frame();
        chk("post_rst_vs1_frame_cnt", FRAME_CNT, 1);
        chk("post_rst_vs1_frame_lines", FRAME_LINES, 0);
        full_frame();
        chk("post_rst_vs2_frame_lines", FRAME_LINES, VT);
        chk("post_rst_vs2_vs_width", VS_WIDTH, VSY);
        chk("post_rst_vs2_err", ERR, 0);
        full_frame();
        full_frame();
        chk("pre_dead_locked", LOCKED, 1);

        // Syncs stuck inactive for three frame times.
        for (int i = 0; i < int'(3 * HT * VT); i++) begin
            pix(1'b0, 1'b0, 1'b0, 1'b0);
        end
`ifdef VGA_MON_TIMEOUT_EN
        chk("dead_err", ERR, 4'b0100);
        chk("dead_locked", LOCKED, 0);
`else
        chk("dead_err", ERR, 0);
        chk("dead_locked", LOCKED, 1);
        chk("dead_line_len", LINE_LEN, HT);
        chk("dead_frame_lines", FRAME_LINES, VT);
`endif
        chk("dead_frame_cnt", FRAME_CNT, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/vga_timing_monitor.md
Name: vga_timing_monitor

Overview:
- Synthesizable sink for the CPU's VGA output (VGA_R/G/B, VGA_HS, VGA_VS).
- Recovers and measures the raster timing: line length, HS width, lines per frame, VS width and lit-pixel count.
- Checks every measurement against the expected 640x480 timing and reports sticky errors plus a lock flag.
- Placed on the board beside CPU for self-check, and instantiated in the testbench as the VGA checker.

Parameters:
PIX_DIV, 2, CLK1_50 cycles per pixel (25 MHz pixel rate)
H_TOTAL, 800, expected HS period in pixels
H_SYNC, 96, expected HS active width in pixels
V_TOTAL, 525, expected lines per frame
V_SYNC, 2, expected VS active width in lines
SYNC_NEG, 1, 1 = syncs active-low, 0 = active-high
LOCK_FRAMES, 2, consecutive clean frames required before LOCKED

Ports:
CLK1_50  in  1  system clock, 50 MHz
RESET  in  1  synchronous, active-high reset
VGA_R  in  4  red from CPU
VGA_G  in  4  green from CPU
VGA_B  in  4  blue from CPU
VGA_HS  in  1  horizontal sync
VGA_VS  in  1  vertical sync
ERR_CLR  in  1  clears ERR; single-cycle pulse
LINE_LEN  out  16  last measured HS period, in pixels
HS_WIDTH  out  16  last measured HS active width, in pixels
FRAME_LINES  out  16  last measured lines per frame
VS_WIDTH  out  16  last measured VS active width, in lines
LIT_PIX  out  20  pixels with RGB != 0 in last completed frame
FRAME_CNT  out  16  completed frames; wraps at 16'hFFFF
LOCKED  out  1  timing stable and matching
ERR  out  4  sticky: [0] LINE_LEN, [1] HS_WIDTH, [2] FRAME_LINES, [3] VS_WIDTH mismatch

Behaviour:
- Clock is CLK1_50 only; RESET is synchronous and active-high.
- RESET zeroes all outputs, counters, sample registers and the pixel divider; state returns to ACQUIRE. Reset mid-frame discards partial measurements.
- Pixel enable: a divider counts 0..PIX_DIV-1 and pulses pix_en on count 0. All inputs are registered once per CLK1_50, and sampling and edge detection occur on pix_en only.
- Active level is hs_act = VGA_HS ^ SYNC_NEG; vs_act is derived the same way.
- Each pixel-domain event is reflected on the outputs 1 CLK1_50 after the pix_en that detects it.
- HS leading edge (inactive to active):
  - LINE_LEN takes the pixel count since the previous leading edge, provided a previous edge exists since reset/ACQUIRE.
  - The pixel counter restarts at 1 and the line counter increments.
  - If vs_act, the VS-width counter increments.
- HS trailing edge: HS_WIDTH takes the count of active pixels.
- VS leading edge:
  - FRAME_LINES takes the line counter.
  - LIT_PIX takes the lit accumulator.
  - FRAME_CNT increments.
  - Both accumulators restart.
- VS trailing edge: VS_WIDTH takes the VS-width line count.
- Lit accumulator: increments on pix_en when {R,G,B} != 0 and neither sync is active.
- Internal counters saturate at all-ones and never wrap. A stalled sync therefore yields 16'hFFFF and a mismatch.
- State machine:
  - ACQUIRE: wait for the first VS leading edge, then go to MEASURE. No outputs update except FRAME_CNT.
  - MEASURE: one full frame, with the first VS-to-VS measurements valid; then go to TRACK.
  - TRACK: compare each new LINE_LEN/HS_WIDTH/FRAME_LINES/VS_WIDTH against H_TOTAL/H_SYNC/V_TOTAL/V_SYNC at capture time. A mismatch sets its ERR bit.
- LOCKED:
  - Sets after LOCK_FRAMES consecutive TRACK frames with no mismatch.
  - Clears in the same cycle as any mismatch, and the clean-frame count restarts.
- ERR is sticky; ERR_CLR clears it. If ERR_CLR coincides with a new mismatch, the new bit is set (set wins). ERR_CLR does not affect LOCKED.
- Simultaneous HS and VS leading edges are processed in order: HS update first, then the VS capture includes that line.

Optional Feature:
VGA_MON_TIMEOUT_EN
- Defined: a watchdog counts pix_en since the last VS leading edge. If it reaches 2*H_TOTAL*V_TOTAL:
  - ERR[2] sets and LOCKED clears.
  - State returns to ACQUIRE and the watchdog restarts.
- Undefined: no watchdog. A dead sync leaves the outputs holding their last values and LOCKED unchanged.

Test Plan:
- Ideal 640x480 raster (800/96/525/2, negative syncs), 3 frames -> LINE_LEN=800, HS_WIDTH=96, FRAME_LINES=525, VS_WIDTH=2, ERR=0; LOCKED=1 after 2nd TRACK frame; FRAME_CNT=3.
- Lit-pixel count: raster with a 10x20 white box, rest black -> LIT_PIX=200 each frame.
- Bad line: one line with 801-pixel period while LOCKED -> ERR[0]=1, LOCKED=0 in the same cycle as the LINE_LEN capture; LOCKED returns after 2 clean frames; ERR[0] stays until ERR_CLR.
- Clear collision: ERR_CLR pulsed in the same cycle a HS_WIDTH=95 mismatch is captured -> ERR=4'b0010.
- RESET asserted mid-frame, then released -> all outputs 0, state ACQUIRE. First measurements appear after the 2nd VS leading edge, and no ERR from the partial frame.
- Syncs held inactive for 3 frames: with VGA_MON_TIMEOUT_EN -> ERR[2]=1, LOCKED=0, state ACQUIRE; without it -> outputs unchanged, ERR=0.
